// File: rtl/uart_sin_rx.sv
// 8N1 serial receiver for the uart_sin pad: two-flop synchroniser, mid-bit sampling
// at a fixed baud divisor, valid/ready byte delivery with framing/overrun pulses.
module uart_sin_rx #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_sin,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int unsigned HALF        = BAUD_DIV / 2;
  localparam logic [15:0] HALF_RELOAD = 16'(HALF - 1);
  localparam logic [15:0] FULL_RELOAD = 16'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;

  logic        r_s1;
  logic        r_s2;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_armed;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_frame_err;
  logic        r_overrun;

  logic        w_cnt_zero;
  logic        w_cnt_load;
  logic [15:0] w_cnt_reload;
  logic        w_shift_en;
  logic        w_idx_clr;
  logic        w_stop_smp;
  logic        w_good;
  logic        w_bad;
  logic        w_xfer;
  logic        w_load;

  // The pad is asynchronous; only r_s2 is used by the receiver.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= uart_sin;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_load   = 1'b0;
    w_cnt_reload = '0;
    w_shift_en   = 1'b0;
    w_idx_clr    = 1'b0;
    w_stop_smp   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!r_s2 && r_armed) begin
          w_state_nxt  = ST_START;
          w_cnt_load   = 1'b1;
          w_cnt_reload = HALF_RELOAD;
        end
      end
      ST_START: begin
        if (w_cnt_zero) begin
          if (r_s2) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt  = ST_DATA;
            w_idx_clr    = 1'b1;
            w_cnt_load   = 1'b1;
            w_cnt_reload = FULL_RELOAD;
          end
        end
      end
      ST_DATA: begin
        if (w_cnt_zero) begin
          w_shift_en   = 1'b1;
          w_cnt_load   = 1'b1;
          w_cnt_reload = FULL_RELOAD;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (w_cnt_zero) begin
          w_stop_smp  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      if (w_cnt_load) begin
        r_cnt <= w_cnt_reload;
      end else if (!w_cnt_zero) begin
        r_cnt <= r_cnt - 16'd1;
      end
      if (w_idx_clr) begin
        r_bit_idx <= '0;
      end else if (w_shift_en) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if (w_shift_en) begin
        r_shift <= {r_s2, r_shift[7:1]};
      end
    end
  end

  assign w_good = w_stop_smp & r_s2;
  assign w_bad  = w_stop_smp & ~r_s2;
  assign w_xfer = r_rx_valid & rx_ready;
  assign w_load = w_good & (~r_rx_valid | rx_ready);

  // Disarmed by a framing error so a held-low line (break) cannot retrigger.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_armed <= 1'b1;
    end else if (w_bad) begin
      r_armed <= 1'b0;
    end else if (r_state == ST_IDLE && r_s2) begin
      r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_load) begin
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
      end else if (w_xfer) begin
        r_rx_valid <= 1'b0;
      end
      r_frame_err <= w_bad;
      r_overrun   <= w_good & r_rx_valid & ~rx_ready;
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign rx_busy   = (r_state != ST_IDLE);

endmodule
